seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scanner for a 4-digit 7-segment display.
// Define SEG_BLINK_EN to build the blink phase for digits selected by blink_mask.
module seg_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_TICKS = 250,
   parameter int LZB         = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic [3:0] dp_in,
   input  logic [3:0] blink_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       slot_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [1:0]    idx;
   logic [3:0]    cur_digit;
   logic          cur_dp;
   logic          hidden;
   logic          lz_blank;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign tick = (pre_cnt == PLAST);

   // Prescaler: one tick per REFRESH_DIV cycles marks the end of a digit slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   // Digit index advances once per slot; slot_tick flags the new slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= 2'd0;
         slot_tick <= 1'b0;
      end else begin
         slot_tick <= tick;
         if (tick) begin
            idx <= idx + 2'd1;
         end
      end
   end

   // Select the digit and decimal-point request of the active slot
   always_comb begin
      cur_digit = digit0;
      cur_dp    = dp_in[0];
      unique case (idx)
         2'd0: begin
            cur_digit = digit0;
            cur_dp    = dp_in[0];
         end
         2'd1: begin
            cur_digit = digit1;
            cur_dp    = dp_in[1];
         end
         2'd2: begin
            cur_digit = digit2;
            cur_dp    = dp_in[2];
         end
         default: begin
            cur_digit = digit3;
            cur_dp    = dp_in[3];
         end
      endcase
   end

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BLAST = BW'(BLINK_TICKS - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_hide;

   // Blink phase flips every BLINK_TICKS slots; mask edits never touch it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt  <= '0;
         blink_hide <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLAST) begin
            blink_cnt  <= '0;
            blink_hide <= ~blink_hide;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign hidden = blink_hide & blink_mask[idx];
`else
   logic unused_blink;

   assign unused_blink = (^blink_mask) ^ (BLINK_TICKS > 0);
   assign hidden       = 1'b0;
`endif

   // Next display value: anode one-hot-low, decode, blanking rules
   always_comb begin
      an_next  = ~(4'b0001 << idx);
      lz_blank = (LZB != 0) && (idx == 2'd3) && (cur_digit == 4'd0);
      seg_next = lz_blank ? 7'h7F : seg_decode(cur_digit);
      dp_next  = ~cur_dp;
      if (hidden) begin
         seg_next = 7'h7F;
         dp_next  = 1'b1;
      end
   end

   // Registered display outputs, refreshed every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: vector table plus reset and mid-slot sequences.
// Expected outputs are queued when inputs are driven and checked a cycle later.
module tb_seg_scan_driver;

   localparam int RD = 4;
   localparam int BT = 2;

   typedef struct packed {
      logic [15:0] dg;
      logic [3:0]  dpi;
      logic [3:0]  msk;
      logic [27:0] sg;
      logic [6:0]  sg3b;
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic [6:0] segb;
      logic       dp;
      logic       st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] d0, d1, d2, d3, dp_in, mask;
   logic [3:0] an, an_b;
   logic [6:0] seg, seg_b;
   logic       dp, dp_b, st, st_b;

   int   e;
   int   ntests = 0;
   int   nfail  = 0;
   vec_t vecs[5];
   vec_t cur;
   vec_t hv;
   exp_t q[$];

   always #5 clk = ~clk;

   seg_scan_driver #(.REFRESH_DIV(RD), .BLINK_TICKS(BT), .LZB(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
      .dp_in(dp_in), .blink_mask(mask),
      .an(an), .seg(seg), .dp(dp), .slot_tick(st)
   );

   seg_scan_driver #(.REFRESH_DIV(RD), .BLINK_TICKS(BT), .LZB(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
      .dp_in(dp_in), .blink_mask(mask),
      .an(an_b), .seg(seg_b), .dp(dp_b), .slot_tick(st_b)
   );

   function automatic vec_t mk(input logic [15:0] dg, input logic [3:0] dpi,
                               input logic [3:0] msk, input logic [27:0] sg,
                               input logic [6:0] sg3b);
      vec_t v;
      v.dg   = dg;
      v.dpi  = dpi;
      v.msk  = msk;
      v.sg   = sg;
      v.sg3b = sg3b;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      cur = v;
      {d3, d2, d1, d0} = v.dg;
      dp_in = v.dpi;
      mask  = v.msk;
   endtask

   // Expected outputs after edge number en since reset release
   function automatic exp_t model(input int en);
      exp_t x;
      int   k;
      logic hid;
      k = ((en - 1) >> 2) & 3;
      x.an = 4'hF;
      x.an[k] = 1'b0;
      x.seg = cur.sg[k*7 +: 7];
      x.segb = (k == 3) ? cur.sg3b : cur.sg[k*7 +: 7];
      x.dp = ~cur.dpi[k];
      x.st = ((en % 4) == 0);
      hid = 1'b0;
`ifdef SEG_BLINK_EN
      hid = ((((en - 1) >> 3) & 1) == 1) && cur.msk[k];
`endif
      if (hid) begin
         x.seg  = 7'h7F;
         x.segb = 7'h7F;
         x.dp   = 1'b1;
      end
      return x;
   endfunction

   task automatic check(input int tag);
      exp_t x, a;
      a = {an, seg, seg_b, dp, st};
      ntests++;
      if (q.size() == 0) begin
         nfail++;
         $display("FAIL scoreboard tag=%0d e=%0d: queue empty", tag, e);
      end else begin
         x = q.pop_front();
         if (a !== x) begin
            nfail++;
            $display("FAIL scan tag=%0d e=%0d got an=%b seg=%h segb=%h dp=%b st=%b want an=%b seg=%h segb=%h dp=%b st=%b",
                     tag, e, a.an, a.seg, a.segb, a.dp, a.st,
                     x.an, x.seg, x.segb, x.dp, x.st);
         end
      end
   endtask

   task automatic step(input int tag);
      q.push_back(model(e + 1));
      @(posedge clk);
      e++;
      @(negedge clk);
      check(tag);
   endtask

   task automatic chk_rst(input int tag);
      logic [12:0] a, ab;
      a  = {an, seg, dp, st};
      ab = {an_b, seg_b, dp_b, st_b};
      ntests++;
      if (a !== {4'hF, 7'h7F, 1'b1, 1'b0} || ab !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         nfail++;
         $display("FAIL reset tag=%0d got an=%b seg=%h dp=%b st=%b b=%h want an=1111 seg=7f dp=1 st=0",
                  tag, an, seg, dp, st, ab);
      end
   endtask

   initial begin
      vecs[0] = mk(16'h1234, 4'b0000, 4'b0000,
                   {7'h79, 7'h24, 7'h30, 7'h19}, 7'h79);
      vecs[1] = mk(16'h08C9, 4'b0100, 4'b0011,
                   {7'h7F, 7'h00, 7'h7F, 7'h10}, 7'h40);
      vecs[2] = mk(16'h765F, 4'b1011, 4'b1111,
                   {7'h78, 7'h02, 7'h12, 7'h7F}, 7'h78);
      vecs[3] = mk(16'h0000, 4'b1000, 4'b0100,
                   {7'h7F, 7'h40, 7'h40, 7'h40}, 7'h40);
      vecs[4] = mk(16'hEABD, 4'b0001, 4'b1010,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 7'h7F);
      hv = mk(16'h0005, 4'b0000, 4'b0000,
              {7'h7F, 7'h40, 7'h40, 7'h12}, 7'h40);

      rst_n = 1'b0;
      e = 0;
      apply(vecs[0]);
      repeat (3) @(negedge clk);
      chk_rst(0);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         apply(vecs[v]);
         for (int s = 0; s < 16 + 5 * v; s++) begin
            step(v + 1);
         end
      end

      for (int s = 0; s < 16; s++) begin
         if (((((e - 1) >> 2) & 3) == 2) && (((e - 1) % 4) == 1)) break;
         step(20);
      end
      rst_n = 1'b0;
      #1;
      chk_rst(21);
      @(posedge clk);
      @(negedge clk);
      chk_rst(22);
      q.delete();
      rst_n = 1'b1;
      e = 0;

      apply(hv);
      step(30);
      step(31);
      hv.dg[3:0] = 4'd6;
      hv.sg[6:0] = 7'h02;
      apply(hv);
      for (int s = 0; s < 6; s++) begin
         step(32 + s);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
